top_tx: RTL and testbench
=========================

TOP_TX -- requirements
Module: top_tx

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: dout_i  output  16  signed in-phase 16-QAM sample, registered.
REQ-004 SHALL have port: dout_q  output  16  signed quadrature 16-QAM sample, registered.
REQ-005 SHALL have parameter: AMP, default 8192, unit amplitude; output levels are ±AMP and ±3*AMP.

Function
REQ-006 SHALL generate payload internally with a PRBS-9 LFSR, polynomial x^9+x^5+1, seed 9'h1FF.
REQ-007 SHALL emit LFSR bit b = lfsr[8] each non-reset cycle, then update lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
REQ-008 SHALL collect bits MSB-first into a 4-bit symbol, using a 2-bit counter cnt that wraps 3->0.
REQ-009 SHALL form symbol = {sr[2:0], b} on the cycle where cnt==3, then shift sr <= {sr[2:0], b} every cycle.
REQ-010 SHALL assign symbol[3:2] to I and symbol[1:0] to Q.
REQ-011 SHALL Gray-map each 2-bit pair: 00->-3, 01->-1, 11->+1, 10->+3, each multiplied by AMP.
REQ-012 SHALL register the mapped values into dout_i/dout_q on the edge where cnt==3.
REQ-013 SHALL hold dout_i/dout_q constant for the following 3 cycles: one symbol per 4 clocks, output changes only every 4th edge.
REQ-014 SHALL update the first output at the 4th rising edge with reset low; latency is 4 clocks from the first payload bit.
REQ-015 SHALL keep levels exact with no saturation (3*8192 = 24576 fits signed 16).
REQ-016 SHALL have PRBS period 511 bits; symbol stream repeats every 511 symbols, since gcd(511,4)=1.

Reset
REQ-017 SHALL, with reset high at a clk edge, set lfsr=9'h1FF, cnt=0, sr=0, dout_i=0, dout_q=0.
REQ-018 SHALL have a reset asserted mid-symbol discard the partial symbol and restart the sequence identically to power-up.
REQ-019 SHALL hold outputs at 0 while reset is held high for any number of cycles.

Structure
REQ-020 SHALL place the Gray-map level constants (±1, ±3), the LFSR seed and the tap positions in shared package qam16_pkg.
REQ-021 SHALL implement the LFSR as sub-module prbs9_gen (ports clk, reset, bit_out); mapping and serial-to-parallel logic stay in top_tx.
REQ-022 SHALL contain no latches; all registers are clocked by clk only.

Verification
REQ-023 SHALL verify reset: hold reset high 10 cycles -> dout_i=0, dout_q=0 throughout.
REQ-024 SHALL verify first symbol: release reset -> at edge 4 dout_i=8192, dout_q=8192 (bits 1111); same again at edge 8.
REQ-025 SHALL verify third symbol: at edge 12 (bits 1000) dout_i=24576, dout_q=-24576.
REQ-026 SHALL verify hold: between symbol edges, outputs unchanged for 3 consecutive cycles.
REQ-027 SHALL verify mid-symbol reset: assert reset 1 cycle at edge 6, release -> sequence restarts; 4th edge after release gives 8192/8192.
REQ-028 SHALL verify periodicity and levels: run 2044+ cycles -> symbol sequence repeats after 511 symbols; every output is in {±8192, ±24576} after the first symbol.

Source files
------------

// File: rtl/qam16_pkg.sv
// Shared constants for the 16-QAM transmitter: PRBS-9 seed/taps and Gray-map levels.
package qam16_pkg;

  localparam logic [8:0] PRBS_SEED   = 9'h1FF;
  localparam int         PRBS_TAP_HI = 8;
  localparam int         PRBS_TAP_LO = 4;

  localparam int signed LVL_N3 = -3;
  localparam int signed LVL_N1 = -1;
  localparam int signed LVL_P1 = 1;
  localparam int signed LVL_P3 = 3;

  // Gray ordering along one axis: adjacent levels differ by one bit
  typedef enum logic [1:0] {
    GRAY_N3 = 2'b00,
    GRAY_N1 = 2'b01,
    GRAY_P1 = 2'b11,
    GRAY_P3 = 2'b10
  } gray_t;

endpackage

// File: rtl/prbs9_gen.sv
// PRBS-9 payload source, x^9+x^5+1, one bit per clock from the register MSB.
module prbs9_gen
  import qam16_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic bit_out
);

  logic [8:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= PRBS_SEED;
    end else begin
      lfsr <= {lfsr[7:0], lfsr[PRBS_TAP_HI] ^ lfsr[PRBS_TAP_LO]};
    end
  end

  assign bit_out = lfsr[PRBS_TAP_HI];

endmodule

// File: rtl/top_tx.sv
// 16-QAM transmitter: PRBS-9 bits are grouped MSB-first into 4-bit symbols and
// Gray-mapped to I/Q levels, one symbol every four clocks.
module top_tx
  import qam16_pkg::*;
#(
  parameter int AMP    = 8192,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic signed [DATA_W-1:0] dout_i,
  output logic signed [DATA_W-1:0] dout_q
);

  logic       b;
  logic [1:0] cnt;
  logic [2:0] sr_p0;
  logic [3:0] sym_p0;
  logic       vld_p0;

  function automatic logic signed [DATA_W-1:0] gray_map(input logic [1:0] pair);
    int signed lvl;
    case (pair)
      GRAY_N3: lvl = LVL_N3;
      GRAY_N1: lvl = LVL_N1;
      GRAY_P1: lvl = LVL_P1;
      default: lvl = LVL_P3;
    endcase
    // 3*AMP stays inside the signed output range, so no clipping is needed
    return DATA_W'(lvl * AMP);
  endfunction

  prbs9_gen u_prbs (
    .clk     (clk),
    .reset   (reset),
    .bit_out (b)
  );

  // Stage p0: the current bit completes the symbol when cnt wraps
  assign sym_p0 = {sr_p0, b};
  assign vld_p0 = (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 2'd0;
      sr_p0  <= 3'd0;
      dout_i <= '0;
      dout_q <= '0;
    end else begin
      cnt   <= cnt + 2'd1;
      sr_p0 <= {sr_p0[1:0], b};
      // Stage p1: outputs hold between symbol boundaries
      if (vld_p0) begin
        dout_i <= gray_map(sym_p0[3:2]);
        dout_q <= gray_map(sym_p0[1:0]);
      end
    end
  end

endmodule

// File: tb/tb_top_tx.sv
// Self-checking bench for top_tx: a scoreboard of expected I/Q per clock,
// built from an independently generated PRBS-9 bit table.
module tb_top_tx;

  localparam int AMP = 8192;
  localparam int PER = 511;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] dout_i;
  logic signed [15:0] dout_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } pair_t;

  pair_t sb[$];
  bit    prbs[0:PER-1];

  top_tx #(.AMP(AMP), .DATA_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .dout_i (dout_i),
    .dout_q (dout_q)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] gmap(input logic [1:0] p);
    case (p)
      2'b00:   return -16'sd24576;
      2'b01:   return -16'sd8192;
      2'b11:   return 16'sd8192;
      default: return 16'sd24576;
    endcase
  endfunction

  // Expected output after the k-th rising edge with reset low (k >= 1)
  function automatic pair_t exp_out(input int k);
    pair_t r;
    int    s;
    int    base;
    logic [3:0] bits;
    s = k / 4;
    if (s == 0) begin
      r.i = 16'sd0;
      r.q = 16'sd0;
    end else begin
      base = (s - 1) * 4;
      for (int j = 0; j < 4; j++) bits[3-j] = prbs[(base + j) % PER];
      r.i = gmap(bits[3:2]);
      r.q = gmap(bits[1:0]);
    end
    return r;
  endfunction

  function automatic bit legal_level(input logic signed [15:0] v);
    return (v == 16'sd8192) || (v == -16'sd8192) || (v == 16'sd24576) || (v == -16'sd24576);
  endfunction

  task automatic build_prbs();
    for (int n = 0; n < 9; n++) prbs[n] = 1'b1;
    for (int n = 9; n < PER; n++) prbs[n] = prbs[n-9] ^ prbs[n-5];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout_i !== 16'sd0 || dout_q !== 16'sd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got i=%0d q=%0d, want 0/0", c, dout_i, dout_q);
      end
    end
  endtask

  task automatic test_first_symbols();
    pair_t e;
    pair_t got;
    logic signed [15:0] prev_i;
    logic signed [15:0] prev_q;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      sb.push_back(exp_out(k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      got.i = dout_i;
      got.q = dout_q;
      checks++;
      if (got.i !== e.i || got.q !== e.q) begin
        errors++;
        $display("FAIL first_sym edge %0d: got i=%0d q=%0d, want i=%0d q=%0d", k, got.i, got.q, e.i, e.q);
      end
      if (k == 4 || k == 8) begin
        checks++;
        if (dout_i !== 16'sd8192 || dout_q !== 16'sd8192) begin
          errors++;
          $display("FAIL sym_1111 edge %0d: got i=%0d q=%0d, want 8192/8192", k, dout_i, dout_q);
        end
      end
      if (k == 12) begin
        checks++;
        if (dout_i !== 16'sd24576 || dout_q !== -16'sd24576) begin
          errors++;
          $display("FAIL sym_1000 edge 12: got i=%0d q=%0d, want 24576/-24576", dout_i, dout_q);
        end
      end
      if (k > 4 && (k % 4) != 0) begin
        checks++;
        if (dout_i !== prev_i || dout_q !== prev_q) begin
          errors++;
          $display("FAIL hold edge %0d: got i=%0d q=%0d, want i=%0d q=%0d", k, dout_i, dout_q, prev_i, prev_q);
        end
      end
      prev_i = dout_i;
      prev_q = dout_q;
    end
  endtask

  task automatic test_mid_reset();
    pair_t e;
    // Restart from a clean state, run into the second symbol, then pulse reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back(exp_out(k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (dout_i !== e.i || dout_q !== e.q) begin
        errors++;
        $display("FAIL pre_reset edge %0d: got i=%0d q=%0d, want i=%0d q=%0d", k, dout_i, dout_q, e.i, e.q);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dout_i !== 16'sd0 || dout_q !== 16'sd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got i=%0d q=%0d, want 0/0", dout_i, dout_q);
    end
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      sb.push_back(exp_out(k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (dout_i !== e.i || dout_q !== e.q) begin
        errors++;
        $display("FAIL restart edge %0d: got i=%0d q=%0d, want i=%0d q=%0d", k, dout_i, dout_q, e.i, e.q);
      end
      if (k == 4) begin
        checks++;
        if (dout_i !== 16'sd8192 || dout_q !== 16'sd8192) begin
          errors++;
          $display("FAIL restart_first: got i=%0d q=%0d, want 8192/8192", dout_i, dout_q);
        end
      end
    end
  endtask

  task automatic test_periodicity();
    pair_t e;
    logic signed [15:0] sym_i[$];
    logic signed [15:0] sym_q[$];
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 2100; k++) begin
      sb.push_back(exp_out(k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (dout_i !== e.i || dout_q !== e.q) begin
        errors++;
        $display("FAIL stream edge %0d: got i=%0d q=%0d, want i=%0d q=%0d", k, dout_i, dout_q, e.i, e.q);
      end
      if (k >= 4) begin
        checks++;
        if (!legal_level(dout_i) || !legal_level(dout_q)) begin
          errors++;
          $display("FAIL level edge %0d: got i=%0d q=%0d, want one of +-8192/+-24576", k, dout_i, dout_q);
        end
      end
      if ((k % 4) == 0) begin
        sym_i.push_back(dout_i);
        sym_q.push_back(dout_q);
      end
    end
    for (int n = 0; n + PER < sym_i.size(); n++) begin
      checks++;
      if (sym_i[n+PER] !== sym_i[n] || sym_q[n+PER] !== sym_q[n]) begin
        errors++;
        $display("FAIL period sym %0d: got i=%0d q=%0d, want i=%0d q=%0d",
                 n + PER, sym_i[n+PER], sym_q[n+PER], sym_i[n], sym_q[n]);
      end
    end
  endtask

  initial begin
    build_prbs();
    test_reset();
    test_first_symbols();
    test_mid_reset();
    test_periodicity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
